// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: receiver state encoding and frame geometry.
package uart_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } rx_state_e;

    localparam int unsigned BitsPerFrame    = 8;
    localparam int unsigned OversampleRatio = 4;
    localparam int unsigned PhaseW          = $clog2(OversampleRatio);
    localparam int unsigned BitIdxW         = $clog2(BitsPerFrame);
    // Phase value at which the line is sampled, near the middle of each bit.
    localparam int unsigned SamplePhase     = 1;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Bus between the UART receiver block and its CPU-side user: line input, baud strobe and FIFO read port.
interface uart_rx_fifo_if #(
    parameter int unsigned CNT_W = 4
);
    import uart_pkg::*;

    logic                    baud_x4;
    logic                    serial;
    logic                    rd_strobe;
    logic                    clr_err;
    logic [BitsPerFrame-1:0] rd_data;
    logic                    rd_valid;
    logic [CNT_W-1:0]        count;
    logic                    framing_err;
    logic                    overrun;

    modport master (
        output baud_x4, serial, rd_strobe, clr_err,
        input  rd_data, rd_valid, count, framing_err, overrun
    );

    modport slave (
        input  baud_x4, serial, rd_strobe, clr_err,
        output rd_data, rd_valid, count, framing_err, overrun
    );

endinterface

// File: rtl/uart_fifo.sv
// First-word fall-through byte FIFO; a push while full is accepted only alongside a pop.
module uart_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CNT_W = 4
) (
    input  logic                    mclk,
    input  logic                    reset,
    input  logic                    push_i,
    input  logic [BitsPerFrame-1:0] wdata_i,
    input  logic                    pop_i,
    output logic [BitsPerFrame-1:0] rdata_o,
    output logic                    full_o,
    output logic                    empty_o,
    output logic [CNT_W-1:0]        count_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);

    logic [BitsPerFrame-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic                    do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
        if (do_push && !do_pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge mclk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// 8-N-1 UART receiver oversampling at 4x the bit rate, feeding received bytes into a FWFT FIFO
// with sticky framing-error and overrun flags.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CNT_W = 4
) (
    input  logic         mclk,
    input  logic         reset,
    uart_rx_fifo_if.slave bus_io
);

    logic [1:0]              sync_q;
    logic                    ser_s;
    rx_state_e               state_q, state_d;
    logic [PhaseW-1:0]       phase_q, phase_d;
    logic [BitIdxW-1:0]      bit_idx_q, bit_idx_d;
    logic [BitsPerFrame-1:0] shift_q, shift_d;
    logic                    tick, sample, wrap;
    logic                    push, fe_set, ov_set;
    logic                    framing_err_q, framing_err_d;
    logic                    overrun_q, overrun_d;
    logic [BitsPerFrame-1:0] fifo_rdata;
    logic                    fifo_full, fifo_empty;
    logic [CNT_W-1:0]        fifo_count;

    always_ff @(posedge mclk or posedge reset) begin
        if (reset) sync_q <= 2'b11;
        else       sync_q <= {sync_q[0], bus_io.serial};
    end
    assign ser_s = sync_q[1];

    assign tick   = bus_io.baud_x4;
    assign sample = tick && (state_q != StIdle) && (phase_q == PhaseW'(SamplePhase));
    assign wrap   = tick && (phase_q == PhaseW'(OversampleRatio - 1));

    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            phase_q   <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        if (tick && (state_q != StIdle)) phase_d = phase_q + PhaseW'(1);
        unique case (state_q)
            StIdle: begin
                if (tick && !ser_s) begin
                    state_d = StStart;
                    phase_d = '0;
                end
            end
            StStart: begin
                // A start bit that has gone high again by mid-bit is treated as line noise.
                if (sample && ser_s) begin
                    state_d = StIdle;
                    phase_d = '0;
                end else if (wrap) begin
                    state_d   = StData;
                    bit_idx_d = '0;
                end
            end
            StData: begin
                if (sample) shift_d = {ser_s, shift_q[BitsPerFrame-1:1]};
                if (wrap) begin
                    if (bit_idx_q == BitIdxW'(BitsPerFrame - 1)) state_d = StStop;
                    else bit_idx_d = bit_idx_q + BitIdxW'(1);
                end
            end
            StStop: begin
                if (sample) begin
                    state_d = StIdle;
                    phase_d = '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        push   = 1'b0;
        fe_set = 1'b0;
        if ((state_q == StStop) && sample) begin
            push   = ser_s;
            fe_set = !ser_s;
        end
    end

    // A pop in the same cycle frees the slot, so only an unaccompanied push into a full FIFO is lost.
    assign ov_set = push && fifo_full && !bus_io.rd_strobe;

    assign framing_err_d = fe_set || (framing_err_q && !bus_io.clr_err);
    assign overrun_d     = ov_set || (overrun_q && !bus_io.clr_err);

    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            framing_err_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            framing_err_q <= framing_err_d;
            overrun_q     <= overrun_d;
        end
    end

    uart_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .mclk    (mclk),
        .reset   (reset),
        .push_i  (push),
        .wdata_i (shift_q),
        .pop_i   (bus_io.rd_strobe),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign bus_io.rd_data     = fifo_rdata;
    assign bus_io.rd_valid    = !fifo_empty;
    assign bus_io.count       = fifo_count;
    assign bus_io.framing_err = framing_err_q;
    assign bus_io.overrun     = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed frames plus random traffic against a queue model.
module tb_uart_rx_fifo;
    import uart_pkg::*;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned CNT_W = 4;

    logic mclk = 1'b0;
    logic reset;
    always #5 mclk = ~mclk;

    uart_rx_fifo_if #(.CNT_W(CNT_W)) bus ();

    uart_rx_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .mclk   (mclk),
        .reset  (reset),
        .bus_io (bus)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    logic [7:0]  model_q[$];
    bit          model_fe;
    bit          model_ov;
    int unsigned rd_pct;
    int unsigned clr_pct;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic check_model();
        logic [7:0] head;
        head = (model_q.size() != 0) ? model_q[0] : 8'h00;
        check_val("count", 32'(bus.count), 32'(model_q.size()));
        check_val("rd_valid", 32'(bus.rd_valid), 32'(model_q.size() != 0));
        check_val("rd_data", 32'(bus.rd_data), 32'(head));
        check_val("framing_err", 32'(bus.framing_err), 32'(model_fe));
        check_val("overrun", 32'(bus.overrun), 32'(model_ov));
    endtask

    // One mclk cycle; push_good/push_bad mark the cycle the bench knows carries the stop sample.
    task automatic cycle(input bit tick, input bit push_good, input bit push_bad,
                         input logic [7:0] data, input bit force_rd);
        bit rd, clr, ov_set;
        rd  = force_rd || ($urandom_range(99) < rd_pct);
        clr = ($urandom_range(99) < clr_pct);
        bus.baud_x4   = tick;
        bus.rd_strobe = rd;
        bus.clr_err   = clr;
        @(posedge mclk);
        ov_set = 1'b0;
        if (rd && (model_q.size() != 0)) void'(model_q.pop_front());
        if (push_good) begin
            if (model_q.size() == DEPTH) ov_set = 1'b1;
            else model_q.push_back(data);
        end
        model_fe = push_bad || (model_fe && !clr);
        model_ov = ov_set || (model_ov && !clr);
        #1;
        bus.baud_x4   = 1'b0;
        bus.rd_strobe = 1'b0;
        bus.clr_err   = 1'b0;
        check_model();
    endtask

    // Quiet cycles before each tick give the synchronizer time to settle on a new line level.
    task automatic send_tick(input bit push_good, input bit push_bad, input logic [7:0] data,
                             input bit force_rd);
        int gap;
        gap = 3 + int'($urandom_range(2));
        for (int i = 0; i < gap; i++) cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        cycle(1'b1, push_good, push_bad, data, force_rd);
    endtask

    task automatic idle_ticks(input int n);
        bus.serial = 1'b1;
        for (int i = 0; i < n; i++) send_tick(1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    // Frame of 10 bit windows, 4 ticks each; the stop bit is sampled on the third tick of its window.
    task automatic send_frame(input logic [7:0] data, input bit stop_ok, input bit rd_at_stop,
                              input int max_ticks);
        logic [9:0] bits;
        int         n;
        bits = {stop_ok, data, 1'b0};
        n    = 0;
        for (int w = 0; w < 10; w++) begin
            bus.serial = bits[w];
            for (int t = 0; t < 4; t++) begin
                if (n == max_ticks) return;
                n++;
                if (w == 9 && t == 2) begin
                    send_tick(stop_ok, !stop_ok, data, rd_at_stop);
                    bus.serial = 1'b1;
                end else begin
                    send_tick(1'b0, 1'b0, 8'h00, 1'b0);
                end
            end
        end
    endtask

    task automatic send_glitch();
        bus.serial = 1'b0;
        send_tick(1'b0, 1'b0, 8'h00, 1'b0);
        bus.serial = 1'b1;
        for (int i = 0; i < 3; i++) send_tick(1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        #1;
        model_q.delete();
        model_fe = 1'b0;
        model_ov = 1'b0;
        check_val("rst_count", 32'(bus.count), 32'd0);
        check_val("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
        check_val("rst_rd_data", 32'(bus.rd_data), 32'd0);
        check_val("rst_framing_err", 32'(bus.framing_err), 32'd0);
        check_val("rst_overrun", 32'(bus.overrun), 32'd0);
        bus.serial = 1'b1;
        repeat (2) @(posedge mclk);
        #1 reset = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_pct = 100;
        cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        clr_pct = 0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1);
    end

    initial begin
        bus.baud_x4   = 1'b0;
        bus.serial    = 1'b1;
        bus.rd_strobe = 1'b0;
        bus.clr_err   = 1'b0;
        rd_pct        = 0;
        clr_pct       = 0;
        apply_reset();
        idle_ticks(3);

        // Single clean frame, then pop it.
        send_frame(8'hA5, 1'b1, 1'b0, 40);
        idle_ticks(2);
        check_val("a5_data", 32'(bus.rd_data), 32'h00A5);
        check_val("a5_count", 32'(bus.count), 32'd1);
        check_val("a5_flags", 32'({bus.framing_err, bus.overrun}), 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        check_val("a5_pop_count", 32'(bus.count), 32'd0);
        check_val("a5_pop_valid", 32'(bus.rd_valid), 32'd0);

        // Short low glitch must be rejected and leave the receiver ready for a real frame.
        send_glitch();
        idle_ticks(4);
        check_val("glitch_count", 32'(bus.count), 32'd0);
        check_val("glitch_flags", 32'({bus.framing_err, bus.overrun}), 32'd0);

        // Bad stop bit, then clear.
        send_frame(8'h3C, 1'b0, 1'b0, 40);
        idle_ticks(2);
        check_val("fe_set", 32'(bus.framing_err), 32'd1);
        check_val("fe_count", 32'(bus.count), 32'd0);
        pulse_clr();
        check_val("fe_clr", 32'(bus.framing_err), 32'd0);

        // Nine frames into an eight-deep FIFO.
        for (int i = 0; i < 9; i++) begin
            send_frame(8'(i), 1'b1, 1'b0, 40);
            idle_ticks(1);
        end
        check_val("ovr_count", 32'(bus.count), 32'd8);
        check_val("ovr_flag", 32'(bus.overrun), 32'd1);
        for (int i = 0; i < 8; i++) begin
            check_val("ovr_pop", 32'(bus.rd_data), 32'(i));
            cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        end
        pulse_clr();
        check_val("ovr_clr", 32'(bus.overrun), 32'd0);

        // Full FIFO with a pop landing on the stop sample of 0x55.
        for (int i = 0; i < 8; i++) begin
            send_frame(8'h10 + 8'(i), 1'b1, 1'b0, 40);
            idle_ticks(1);
        end
        send_frame(8'h55, 1'b1, 1'b1, 40);
        idle_ticks(1);
        check_val("coinc_count", 32'(bus.count), 32'd8);
        check_val("coinc_overrun", 32'(bus.overrun), 32'd0);
        for (int i = 0; i < 7; i++) cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        check_val("coinc_last", 32'(bus.rd_data), 32'h0055);
        cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        check_val("coinc_empty", 32'(bus.rd_valid), 32'd0);

        // Reset in the middle of data bit 4 of 0x81; only the following frame may arrive.
        send_frame(8'h81, 1'b1, 1'b0, 22);
        apply_reset();
        idle_ticks(2);
        send_frame(8'h7E, 1'b1, 1'b0, 40);
        idle_ticks(2);
        check_val("rstmid_count", 32'(bus.count), 32'd1);
        check_val("rstmid_data", 32'(bus.rd_data), 32'h007E);
        cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);

        // Random traffic: bytes, bad stops, glitches, reads and clears at varying rates.
        for (int f = 0; f < 60; f++) begin
            int unsigned kind;
            rd_pct  = $urandom_range(4);
            clr_pct = $urandom_range(2);
            kind    = $urandom_range(9);
            if (kind == 0) send_glitch();
            else send_frame(8'($urandom), kind != 1, $urandom_range(3) == 0, 40);
            idle_ticks(int'($urandom_range(3)));
        end
        rd_pct  = 0;
        clr_pct = 0;
        while (model_q.size() != 0) cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter DEPTH, default 8, FIFO entries (power of two, 2..64).
REQ-002 Parameter CNT_W, default 4, width of count = log2(DEPTH)+1.
REQ-003 mclk  input  1  system clock; all logic on posedge.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 baud_x4  input  1  one-mclk strobe at 4x bit rate (from uart_clk).
REQ-006 serial  input  1  asynchronous RS-232 8-N-1 line, idle high.
REQ-007 rd_strobe  input  1  one-cycle pop request from CPU side.
REQ-008 clr_err  input  1  clears sticky error flags.
REQ-009 rd_data  output  8  FIFO head byte, first-word fall-through.
REQ-010 rd_valid  output  1  FIFO not empty.
REQ-011 count  output  CNT_W  bytes held, 0..DEPTH.
REQ-012 framing_err  output  1  sticky: stop bit sampled low.
REQ-013 overrun  output  1  sticky: byte received while FIFO full.

Function
REQ-014 serial SHALL pass through a two-FF synchronizer, both FFs reset to 1; only the synchronized value (ser_s) is used.
REQ-015 Receiver state and 2-bit phase counter SHALL advance only on mclk cycles with baud_x4=1.
REQ-016 States: IDLE, START, DATA, STOP; bit index 0..7 in DATA.
REQ-017 IDLE: on tick with ser_s=0 -> START, phase=0.
REQ-018 Each tick outside IDLE SHALL increment phase mod 4; sampling occurs on tick where phase==1 before increment.
REQ-019 START sample with ser_s=1 -> IDLE (glitch rejected, no flags); else continue; phase 3->0 wrap -> DATA, bit index 0.
REQ-020 DATA sample SHALL shift ser_s in LSB first; wrap after bit 7 -> STOP.
REQ-021 STOP sample: ser_s=1 -> push byte; ser_s=0 -> set framing_err, no push; either case -> IDLE on same tick.
REQ-022 Push SHALL occur in the cycle of the stop sample; byte visible on rd_data next cycle if FIFO was empty.
REQ-023 rd_strobe with rd_valid=1 SHALL pop head; rd_strobe when empty SHALL be ignored.
REQ-024 Push while full without simultaneous pop: byte discarded, overrun set, FIFO unchanged.
REQ-025 Push and pop in same cycle (any non-empty level incl. full): both performed, count unchanged, no overrun.
REQ-026 Pointers SHALL wrap modulo DEPTH; count SHALL equal pushes minus pops exactly.
REQ-027 rd_data SHALL be 0 when rd_valid=0.
REQ-028 Flag set and clr_err in same cycle: set wins.
REQ-029 baud_x4 absent: receiver state frozen; FIFO reads still serviced.

Reset
REQ-030 Reset SHALL force IDLE, phase 0, synchronizer 1, pointers 0, count 0, rd_valid 0, rd_data 0, framing_err 0, overrun 0.
REQ-031 Reset mid-frame SHALL abandon the partial byte; no push after release until a new start bit.
REQ-032 FIFO storage array needs no reset.

Structure
REQ-033 Shared package uart_pkg SHALL hold receiver state encoding, bits-per-frame (8), oversample ratio (4).
REQ-034 FIFO SHALL be sub-module uart_fifo (DEPTH param, push/pop/full/empty/count, FWFT head).

Verification
REQ-035 Frame 0xA5 at 4 ticks/bit -> one push, rd_data=0xA5, count=1, no flags; rd_strobe -> count=0, rd_valid=0.
REQ-036 Low glitch 1 tick then high -> no push, state IDLE, no flags.
REQ-037 Frame 0x3C with stop bit low -> framing_err=1, count=0; clr_err -> framing_err=0.
REQ-038 9 frames 0x00..0x08 without reads (DEPTH=8) -> count=8, overrun=1, pops return 0x00..0x07.
REQ-039 FIFO full, rd_strobe coinciding with stop sample of 0x55 -> count stays 8, overrun=0, 0x55 last out.
REQ-040 Reset asserted at DATA bit 4 of 0x81, released, then frame 0x7E -> only 0x7E received.
